multitimer: RTL

MULTITIMER -- requirements
Module: multitimer

---
 rtl/multitimer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/multitimer.sv
// Byte-wide bus peripheral with CHANNELS independent prescaled timers and a sticky IRQ per channel.
// Define MULTITIMER_LATCH_EN to snapshot the counter on an offset-1 read for coherent reads.
module multitimer #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned WIDTH    = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] AD,
  input  logic [7:0] DI,
  output logic [7:0] DO,
  input  logic       rw,
  input  logic       cs,
  output logic       irq
);

  // mode_q holds MODE bits 6..0; bit 7 (IRQ) lives in irq_q
  logic [6:0]       mode_q  [CHANNELS];
  logic [6:0]       mode_d  [CHANNELS];
  logic             irq_q   [CHANNELS];
  logic             irq_d   [CHANNELS];
  logic [WIDTH-1:0] presc_q [CHANNELS];
  logic [WIDTH-1:0] presc_d [CHANNELS];
  logic [WIDTH-1:0] cnt_q   [CHANNELS];
  logic [WIDTH-1:0] cnt_d   [CHANNELS];
`ifdef MULTITIMER_LATCH_EN
  logic [WIDTH-1:0] latch_q [CHANNELS];
  logic [WIDTH-1:0] latch_d [CHANNELS];
`endif
  logic [7:0]       rdata_q;
  logic [7:0]       rdata_d;

  // Offset 1/2/3 selects bits 23..16 / 15..8 / 7..0 of a zero-extended value
  function automatic logic [7:0] get_byte(input logic [23:0] v, input logic [1:0] off);
    case (off)
      2'd1:    return v[23:16];
      2'd2:    return v[15:8];
      2'd3:    return v[7:0];
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [23:0] put_byte(input logic [23:0] v, input logic [1:0] off,
                                           input logic [7:0] b);
    logic [23:0] r;
    r = v;
    case (off)
      2'd1:    r[23:16] = b;
      2'd2:    r[15:8]  = b;
      2'd3:    r[7:0]   = b;
      default: r = v;
    endcase
    return r;
  endfunction

  function automatic logic byte_in_width(input logic [1:0] off);
    case (off)
      2'd1:    return WIDTH > 16;
      2'd2:    return WIDTH > 8;
      2'd3:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    logic        sel;
    logic        wr;
    logic        rd;
    logic        run;
    logic        match;
    logic [23:0] presc_ext;
    logic [23:0] cnt_ext;

    sel       = 1'b0;
    wr        = 1'b0;
    rd        = 1'b0;
    run       = 1'b0;
    match     = 1'b0;
    presc_ext = '0;
    cnt_ext   = '0;

    rdata_d = rdata_q;
    // Unmapped channels read as zero; a mapped channel overrides below
    if (cs && rw) begin
      rdata_d = 8'h00;
    end

    for (int i = 0; i < CHANNELS; i++) begin
      sel       = cs && (AD[3:2] == 2'(i));
      wr        = sel && !rw;
      rd        = sel && rw;
      run       = mode_q[i][0];
      match     = run && (cnt_q[i] == presc_q[i]);
      presc_ext = 24'(presc_q[i]);
      cnt_ext   = 24'(cnt_q[i]);

      mode_d[i]  = mode_q[i];
      irq_d[i]   = irq_q[i];
      presc_d[i] = presc_q[i];
      cnt_d[i]   = cnt_q[i];
`ifdef MULTITIMER_LATCH_EN
      latch_d[i] = latch_q[i];
`endif

      if (run) begin
        cnt_d[i] = match ? '0 : cnt_q[i] + WIDTH'(1);
      end
      if (match) begin
        irq_d[i] = 1'b1;
        if (mode_q[i][5]) begin
          mode_d[i][0] = 1'b0;
        end
      end

      // A MODE write lands after the one-shot stop, so setting RUN on a match edge wins
      if (wr && (AD[1:0] == 2'd0)) begin
        mode_d[i] = DI[6:0];
      end
      if (wr && (AD[1:0] != 2'd0) && byte_in_width(AD[1:0])) begin
        presc_d[i] = WIDTH'(put_byte(presc_ext, AD[1:0], DI));
        cnt_d[i]   = '0;
      end

      if (rd) begin
        if (AD[1:0] == 2'd0) begin
          rdata_d = {irq_q[i], mode_q[i]};
          if (!match) begin
            irq_d[i] = 1'b0;
          end
        end else if (run) begin
`ifdef MULTITIMER_LATCH_EN
          if (AD[1:0] == 2'd1) begin
            latch_d[i] = cnt_q[i];
            rdata_d    = get_byte(cnt_ext, AD[1:0]);
          end else begin
            rdata_d = get_byte(24'(latch_q[i]), AD[1:0]);
          end
`else
          rdata_d = get_byte(cnt_ext, AD[1:0]);
`endif
        end else begin
          rdata_d = get_byte(presc_ext, AD[1:0]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata_q <= 8'h00;
      for (int i = 0; i < CHANNELS; i++) begin
        mode_q[i]  <= '0;
        irq_q[i]   <= 1'b0;
        presc_q[i] <= '0;
        cnt_q[i]   <= '0;
`ifdef MULTITIMER_LATCH_EN
        latch_q[i] <= '0;
`endif
      end
    end else begin
      rdata_q <= rdata_d;
      for (int i = 0; i < CHANNELS; i++) begin
        mode_q[i]  <= mode_d[i];
        irq_q[i]   <= irq_d[i];
        presc_q[i] <= presc_d[i];
        cnt_q[i]   <= cnt_d[i];
`ifdef MULTITIMER_LATCH_EN
        latch_q[i] <= latch_d[i];
`endif
      end
    end
  end

  always_comb begin
    irq = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      irq = irq | (irq_q[i] & mode_q[i][6]);
    end
  end

  assign DO = rdata_q;

endmodule
